// File: rtl/oam_dma_engine_pkg.sv
// Shared video definitions for the OAM DMA engine: register map,
// OAM window geometry and the DMA sequencer state encoding.
package oam_dma_engine_pkg;

    // CPU-visible trigger register and the OAM destination window
    localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
    localparam logic [15:0] OAM_LOC         = 16'hFE00;
    localparam int          OAM_SIZE        = 160;   // 40 sprites x 4 bytes
    localparam int          DMA_START_DELAY = 1;

    // Sequencer state encoding, kept as plain constants so older tools
    // and waveform scripts see stable numeric codes
    typedef logic [2:0] dma_state_t;
    localparam dma_state_t ST_IDLE  = 3'd0;
    localparam dma_state_t ST_START = 3'd1;
    localparam dma_state_t ST_REQ   = 3'd2;
    localparam dma_state_t ST_RD    = 3'd3;
    localparam dma_state_t ST_CAP   = 3'd4;
    localparam dma_state_t ST_WR    = 3'd5;

    // Destination address: base plus byte index, wrapping within 16 bits
    function automatic logic [15:0] oam_dst_addr(input logic [15:0] base,
                                                 input logic [7:0]  idx);
        return base + {8'h00, idx};
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a CPU write to the DMA register copies XFER_LEN bytes
// from {src,idx} into the OAM window, one read/capture/write triple per
// byte, mastering the system bus through a req/gnt handshake.
module oam_dma_engine
    import oam_dma_engine_pkg::*;
#(
    parameter logic [15:0] REG_ADDR    = DMA_REG_ADDR,
    parameter logic [15:0] DST_BASE    = OAM_LOC,
    parameter int          XFER_LEN    = OAM_SIZE,
    parameter int          START_DELAY = DMA_START_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
    localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dly_q, dly_d;
    logic [7:0] byte_q, byte_d;

    logic trig;
    logic last;
    logic in_rd, in_wr, owns_bus;

    assign trig = cpu_wr && (cpu_addr == REG_ADDR);
    assign last = (idx_q == LAST_IDX);

    // Next-state logic: sequencer walk, with a trigger overriding everything
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (dly_q == DLY_LAST) state_d = ST_REQ;
                else                   dly_d   = dly_q + 8'd1;
            end
            ST_REQ: begin
                if (bus_gnt) state_d = ST_RD;
            end
            ST_RD: begin
                // Losing the grant before the data returns forces a re-read
                state_d = bus_gnt ? ST_CAP : ST_REQ;
            end
            ST_CAP: begin
                byte_d  = bus_rdata;
                state_d = bus_gnt ? ST_WR : ST_REQ;
            end
            ST_WR: begin
                // Without the grant the captured byte is held and the write retried
                if (bus_gnt) begin
                    if (last) begin
                        state_d = ST_IDLE;
                        idx_d   = 8'd0;
                    end else begin
                        state_d = ST_RD;
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (trig) begin
            src_d   = cpu_wdata;
            idx_d   = 8'd0;
            dly_d   = 8'd0;
            state_d = ST_START;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= 8'd0;
            idx_q   <= 8'd0;
            dly_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
        end
    end

    // Captured data byte; only observed through the WR-qualified write data
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    // Bus-master strobes decoded from state; reset silences them in the same cycle
    always_comb begin
        in_rd    = (state_q == ST_RD) && !reset;
        in_wr    = (state_q == ST_WR) && !reset;
        owns_bus = (state_q == ST_REQ || state_q == ST_RD ||
                    state_q == ST_CAP || state_q == ST_WR) && !reset;

        dma_active = (state_q != ST_IDLE) && !reset;
        bus_req    = owns_bus;
        bus_rd     = in_rd && bus_gnt;
        // A retrigger cancels an in-flight write, except the final one
        bus_wr     = in_wr && bus_gnt && !(trig && !last);

        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        if (in_rd) begin
            bus_addr = {src_q, idx_q};
        end else if (in_wr) begin
            bus_addr  = oam_dst_addr(DST_BASE, idx_q);
            bus_wdata = byte_q;
        end

        cpu_rdata_en = cpu_rd && (cpu_addr == REG_ADDR) && !reset;
        cpu_rdata    = cpu_rdata_en ? src_q : 8'h00;
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: a bus memory model answers reads
// one cycle after bus_rd, and every OAM write is matched against an
// expected queue filled when each transfer is triggered.
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_wr, cpu_rd;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_en;
    logic        bus_req, bus_gnt;
    logic [15:0] bus_addr;
    logic        bus_rd, bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_active;

    oam_dma_engine dut (
        .clk(clk), .reset(reset),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdata_en(cpu_rdata_en),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];
    logic [23:0] exp_q [$];
    int          wr_count = 0;
    int          rd_watch_cnt = 0;
    logic [15:0] rd_watch_addr = 16'h0000;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus memory read data, valid the cycle after bus_rd
    always @(posedge clk) begin
        if (rd_pend) bus_rdata <= mem[rd_addr];
    end

    // Monitor sampled mid-cycle: record reads, score writes
    always @(negedge clk) begin
        rd_pend = bus_rd;
        rd_addr = bus_addr;
        if (bus_rd && bus_addr == rd_watch_addr) rd_watch_cnt++;
        if (bus_wr) begin
            logic [23:0] e;
            wr_count++;
            check("rd_wr_exclusive", {31'd0, bus_rd}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {8'd0, bus_addr, bus_wdata}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("oam_wr", {8'd0, bus_addr, bus_wdata}, {8'd0, e});
            end
            if (bus_addr[15:8] == 8'hFE) oam[bus_addr[7:0]] = bus_wdata;
        end
    end

    // Drive a DMA trigger for one cycle (caller aligned just after posedge)
    task automatic trigger(input logic [7:0] src, input bit flush);
        if (flush) exp_q.delete();
        for (int i = 0; i < 160; i++)
            exp_q.push_back({16'hFE00 + 16'(i), mem[{src, 8'(i)}]});
        cpu_addr  = 16'hFF46;
        cpu_wdata = src;
        cpu_wr    = 1'b1;
        @(posedge clk); #1;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (dma_active === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, dma_active}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rd(input logic [15:0] a, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_rd && bus_addr == a) && n < bound);
        check("rd_wait_timeout", {31'd0, (bus_rd && bus_addr == a)}, 32'd1);
    endtask

    initial begin
        int cnt;
        int base;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 9) ^ 8'h5A;
        for (int a = 0; a < 256; a++) oam[a] = 8'h00;
        reset = 1'b1; bus_gnt = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {26'd0, bus_req, bus_rd, bus_wr, dma_active, cpu_rdata_en, 1'b0}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {8'd0, bus_addr, bus_wdata}, 32'd0);
        @(posedge clk); #1;

        // 1: full copy with grant held, measure dma_active length
        trigger(8'hC0, 1'b1);
        cnt = 0;
        while (cnt < 2000) begin
            @(negedge clk);
            if (!dma_active) break;
            cnt++;
        end
        check("active_cycles", cnt, 482);
        check("q_empty_t1", exp_q.size(), 0);
        check("oam_t1_first", {24'd0, oam[8'h00]}, {24'd0, mem[16'hC000]});
        check("oam_t1_last",  {24'd0, oam[8'h9F]}, {24'd0, mem[16'hC09F]});
        @(posedge clk); #1;

        // 2: grant drop in CAP at idx 37 forces one re-read
        rd_watch_addr = 16'hC025;
        rd_watch_cnt  = 0;
        trigger(8'hC0, 1'b1);
        wait_rd(16'hC025, 1000);
        @(posedge clk); #1 bus_gnt = 1'b0;
        @(negedge clk);
        check("req_held_no_gnt", {30'd0, bus_req, bus_rd}, 32'd2);
        repeat (5) @(posedge clk);
        #1 bus_gnt = 1'b1;
        wait_idle(1000);
        check("reread_count", rd_watch_cnt, 2);
        check("q_empty_t2", exp_q.size(), 0);

        // 3: retrigger with D0 once 80 bytes are written
        trigger(8'hB3, 1'b1);
        base = wr_count;
        cnt = 0;
        while (wr_count - base < 80 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_progress", wr_count - base, 80);
        @(posedge clk); #1;
        trigger(8'hD0, 1'b1);
        wait_idle(1000);
        check("q_empty_t3", exp_q.size(), 0);
        check("oam_t3_0",  {24'd0, oam[8'h00]}, {24'd0, mem[16'hD000]});
        check("oam_t3_80", {24'd0, oam[8'h50]}, {24'd0, mem[16'hD050]});
        check("oam_t3_9f", {24'd0, oam[8'h9F]}, {24'd0, mem[16'hD09F]});

        // 4: reset at idx 50 aborts immediately
        trigger(8'h44, 1'b1);
        base = wr_count;
        cnt = 0;
        while (wr_count - base < 50 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_strobes", {28'd0, bus_req, bus_rd, bus_wr, dma_active}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_strobes", {28'd0, bus_req, bus_rd, bus_wr, dma_active}, 32'd0);
        base = wr_count;
        repeat (20) @(negedge clk);
        check("no_wr_after_rst", wr_count - base, 0);
        @(posedge clk); #1 cpu_rd = 1'b1; cpu_addr = 16'hFF46;
        @(negedge clk);
        check("rdata_after_rst", {23'd0, cpu_rdata_en, cpu_rdata}, {23'd0, 1'b1, 8'h00});
        @(posedge clk); #1 cpu_rd = 1'b0; cpu_addr = 16'h0000;

        // 5: register readback and a write to an unrelated address
        cpu_addr = 16'hFF47; cpu_wdata = 8'h99; cpu_wr = 1'b1;
        @(posedge clk); #1 cpu_wr = 1'b0;
        @(negedge clk);
        check("other_addr_ignored", {31'd0, dma_active}, 32'd0);
        @(posedge clk); #1;
        trigger(8'h8A, 1'b1);
        cpu_rd = 1'b1; cpu_addr = 16'hFF46;
        @(negedge clk);
        check("rdata_8a", {23'd0, cpu_rdata_en, cpu_rdata}, {23'd0, 1'b1, 8'h8A});
        @(posedge clk); #1 cpu_rd = 1'b0;
        @(negedge clk);
        check("rdata_en_pulse", {31'd0, cpu_rdata_en}, 32'd0);

        // 6: trigger in the same cycle as the final write
        wait_rd(16'h8A9F, 1000);
        @(posedge clk); #1;       // CAP
        @(posedge clk); #1;       // WR of idx 159
        trigger(8'h12, 1'b0);
        check("fe9f_written", {24'd0, oam[8'h9F]}, {24'd0, mem[16'h8A9F]});
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("active_after_retrig", {31'd0, dma_active}, 32'd1);
            if (bus_rd) break;
        end
        check("restart_latency", cnt, 3);
        check("restart_addr", {16'd0, bus_addr}, 32'h1200);
        wait_idle(1000);
        check("q_empty_t6", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
